// File: rtl/compare_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : compare_seq_ctrl
// Description : WIDTH-bit magnitude compare built by time-sharing a single
//               external 4-bit cascadable comparator, one nibble per cycle,
//               LSB-first, with each result fed back as the next cascade.
//               Supports unsigned and two's-complement operands, returns a
//               one-hot {gt,lt,eq} result with a done pulse, and flags
//               malformed comparator responses.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_seq_ctrl #(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oResult,
    output logic             oErr,
    output logic [3:0]       oCmpA,
    output logic [3:0]       oCmpB,
    output logic [2:0]       oCmpCas,
    input  logic [2:0]       iCmpRes
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB);
    localparam int IDX_W = CNT_W + 2;

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);
    localparam logic [2:0]       CAS_EQ   = 3'b001;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regA_q, regA_d;
    logic [WIDTH-1:0]  regB_q, regB_d;
    logic              signed_q, signed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        cas_q, cas_d;
    logic [2:0]        result_q, result_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              w_last;
    logic [IDX_W-1:0]  w_idx;
    logic [3:0]        w_nib_a;
    logic [3:0]        w_nib_b;
    logic              w_flip;
    logic              w_onehot;

    // Select the current nibble; in signed mode the top nibble's MSB is
    // inverted so an unsigned nibble compare yields two's-complement order.
    always_comb begin
        w_last   = (cnt_q == LAST_NIB);
        w_idx    = {cnt_q, 2'b00};
        w_nib_a  = regA_q[w_idx +: 4];
        w_nib_b  = regB_q[w_idx +: 4];
        w_flip   = signed_q & w_last;
        w_onehot = (iCmpRes == 3'b100) || (iCmpRes == 3'b010) || (iCmpRes == 3'b001);
    end

    // Comparator drive: quiet nibbles and a neutral cascade while idle.
    always_comb begin
        oCmpA   = 4'h0;
        oCmpB   = 4'h0;
        oCmpCas = CAS_EQ;
        if (state_q == S_RUN) begin
            oCmpA   = w_nib_a ^ {w_flip, 3'b000};
            oCmpB   = w_nib_b ^ {w_flip, 3'b000};
            oCmpCas = cas_q;
        end
    end

    // Next-state and datapath update for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        regA_d   = regA_q;
        regB_d   = regB_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        cas_d    = cas_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d  = S_RUN;
                    regA_d   = iA;
                    regB_d   = iB;
                    signed_d = iSigned;
                    cnt_d    = '0;
                    cas_d    = CAS_EQ;
                    err_d    = 1'b0;
                end
            end
            S_RUN: begin
                cas_d = iCmpRes;
                if (!w_onehot) begin
                    err_d = 1'b1;
                end
                if (w_last) begin
                    // A malformed response is passed to the result unchanged.
                    result_d = iCmpRes;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any compare in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            regA_q   <= '0;
            regB_q   <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            cas_q    <= CAS_EQ;
            result_q <= 3'b000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            regA_q   <= regA_d;
            regB_q   <= regB_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            cas_q    <= cas_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Status outputs come straight from registers.
    always_comb begin
        oBusy   = (state_q == S_RUN);
        oDone   = done_q;
        oResult = result_q;
        oErr    = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_compare_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_seq_ctrl
// Description : Scoreboard bench for compare_seq_ctrl with a behavioural
//               4-bit cascadable comparator and a whole-word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    logic             err;
    logic [3:0]       cmp_a;
    logic [3:0]       cmp_b;
    logic [2:0]       cmp_cas;
    logic [2:0]       cmp_res;
    logic             bad_active;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [7:0] q_nib[$];
    logic [3:0] q_res[$];
    int         q_cyc[$];
    logic [2:0] last_res = 3'b000;
    logic       last_err = 1'b0;

    compare_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iStart  (start),
        .iSigned (sgn),
        .iA      (a_in),
        .iB      (b_in),
        .oBusy   (busy),
        .oDone   (done),
        .oResult (result),
        .oErr    (err),
        .oCmpA   (cmp_a),
        .oCmpB   (cmp_b),
        .oCmpCas (cmp_cas),
        .iCmpRes (cmp_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit cascadable comparator, with an injectable bad response.
    always_comb begin
        cmp_res = cmp_cas;
        if (bad_active)         cmp_res = 3'b011;
        else if (cmp_a > cmp_b) cmp_res = 3'b100;
        else if (cmp_a < cmp_b) cmp_res = 3'b010;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Whole-word reference: signed order via sign-bit flip, then plain compare.
    // With a fault on nibble k, the bad code survives unless a higher part differs.
    function automatic logic [2:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s, input int bad);
        logic [WIDTH-1:0] ua, ub;
        ua = a ^ (s ? 16'h8000 : 16'h0000);
        ub = b ^ (s ? 16'h8000 : 16'h0000);
        if (bad >= 0) begin
            if (bad == NIB - 1) return 3'b011;
            ua = ua >> (4 * (bad + 1));
            ub = ub >> (4 * (bad + 1));
            if (ua == ub) return 3'b011;
        end
        if (ua > ub) return 3'b100;
        if (ua < ub) return 3'b010;
        return 3'b001;
    endfunction

    // Scoreboard monitor: checks presented nibbles, results and held state.
    always @(negedge clk) begin
        logic [7:0] en;
        logic [3:0] er;
        int         ec;
        if (!rst_n) begin
            chk("done_during_reset", done, 0);
        end else begin
            if (busy) begin
                if (q_nib.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    en = q_nib.pop_front();
                    chk("nibble_a", cmp_a, en[7:4]);
                    chk("nibble_b", cmp_b, en[3:0]);
                end
            end
            if (done) begin
                if (q_res.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    er = q_res.pop_front();
                    ec = q_cyc.pop_front();
                    chk("result", result, er[2:0]);
                    chk("err_at_done", err, er[3]);
                    chk("done_cycle", cyc, ec);
                    chk("busy_in_done_cycle", busy, 0);
                    last_res = er[2:0];
                    last_err = er[3];
                end
            end else if (!busy) begin
                chk("held_result", result, last_res);
                chk("held_err", err, last_err);
                chk("idle_cmp_a", cmp_a, 0);
                chk("idle_cas", cmp_cas, 3'b001);
            end
        end
    end

    // Issue one compare, starting at the next falling edge (DUT assumed idle).
    task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input int bad, input bit extra);
        logic [3:0] na, nb;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sgn = s;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NIB; k++) begin
            na = a[4*k +: 4];
            nb = b[4*k +: 4];
            if (s && k == NIB - 1) begin
                na[3] = ~na[3];
                nb[3] = ~nb[3];
            end
            q_nib.push_back({na, nb});
        end
        q_res.push_back({(bad >= 0), ref_model(a, b, s, bad)});
        q_cyc.push_back(cyc + NIB);
        for (int k = 0; k < NIB; k++) begin
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
            sgn  = 1'($urandom);
            bad_active = (k == bad);
            start = extra && (k < 2);
            @(posedge clk); #1;
            bad_active = 1'b0;
            start = 1'b0;
        end
    endtask

    // Start a compare and assert reset once two nibbles have been consumed.
    task automatic cmp_with_reset(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        q_nib.push_back({a[3:0], b[3:0]});
        q_nib.push_back({a[7:4], b[7:4]});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 3'b000);
        chk("rst_err", err, 0);
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_cmp_b", cmp_b, 0);
        chk("rst_cas", cmp_cas, 3'b001);
        q_nib.delete();
        q_res.delete();
        q_cyc.delete();
        last_res = 3'b000;
        last_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int               mode, bad;
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0; bad_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_result", result, 3'b000);
        chk("init_err", err, 0);
        chk("init_cas", cmp_cas, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed cases.
        do_cmp(16'h1234, 16'h1234, 1'b0, -1, 1'b0);
        repeat (2) @(posedge clk);
        do_cmp(16'h1235, 16'h1234, 1'b0, -1, 1'b0);
        do_cmp(16'h0FFF, 16'h1000, 1'b0, -1, 1'b0);   // back-to-back
        do_cmp(16'h8000, 16'h0001, 1'b0, -1, 1'b0);
        do_cmp(16'h8000, 16'h0001, 1'b1, -1, 1'b0);
        do_cmp(16'hFFFF, 16'hFFFE, 1'b1, -1, 1'b0);
        do_cmp(16'h7FFF, 16'h8000, 1'b1, -1, 1'b0);
        repeat (1) @(posedge clk);
        do_cmp(16'h00A0, 16'h00B0, 1'b0, -1, 1'b1);   // extra starts ignored
        repeat (2) @(posedge clk);
        cmp_with_reset(16'hABCD, 16'h1234);
        repeat (1) @(posedge clk);
        do_cmp(16'h4321, 16'h4322, 1'b0, -1, 1'b0);
        do_cmp(16'h1234, 16'h1234, 1'b0, 1, 1'b0);    // bad response on nibble 1
        repeat (2) @(posedge clk);
        do_cmp(16'h0001, 16'h0000, 1'b0, -1, 1'b0);   // error cleared on start

        // Randomized compares.
        for (int i = 0; i < 200; i++) begin
            mode = $urandom_range(0, 9);
            ra   = WIDTH'($urandom);
            if (mode < 3)      rb = ra;
            else if (mode < 6) rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
            else               rb = WIDTH'($urandom);
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NIB - 1)) : -1;
            do_cmp(ra, rb, 1'($urandom), bad, ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q_nib.size() + q_res.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
